// File: rtl/pipe_reg_chain.sv
// Purpose: elastic WIDTH-bit register chain of DEPTH stages with valid/ready, bubble collapse, flush and occupancy count.
// Latency: DEPTH-1 cycles after the accepting edge when never stalled (DEPTH=1: visible right after acceptance).
// Backpressure: out_ready ripples combinationally to in_ready; empty stages always accept so gaps close under stall.
module pipe_reg_chain #(
  parameter int unsigned            WIDTH     = 8,
  parameter int unsigned            DEPTH     = 4,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_in,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           d_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           q_output,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  // Stage 0 is the input side; stage DEPTH-1 drives the output.
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] accept;
  logic             push;
  logic             pop;

  // A stage accepts when it is empty or everything downstream of it can move.
  // Written as "not all stages from i to the end are full, or the consumer
  // takes", which is the unrolled form of accept[i] = ~v[i] | take[i] and
  // avoids a bit-level self-dependency on the accept vector.
  always_comb begin
    logic all_full;
    accept   = '0;
    all_full = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      all_full = 1'b1;
      for (int j = i; j < DEPTH; j++) begin
        all_full = all_full & v[j];
      end
      accept[i] = ~all_full | out_ready;
    end
  end

  // Output-side view and handshake events that move the occupancy counter.
  always_comb begin
    in_ready  = accept[0] & ~flush;
    q_output  = data[DEPTH-1];
    out_valid = v[DEPTH-1];
    push      = in_valid & in_ready;
    pop       = v[DEPTH-1] & out_ready;
  end

  // Stage registers: flush clears valids only, data loads only behind a valid.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data[i] <= RESET_VAL;
      end
    end else if (flush) begin
      v <= '0;
    end else begin
      if (accept[0]) begin
        v[0] <= in_valid;
        if (in_valid) begin
          data[0] <= d_in;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (accept[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) begin
            data[i] <= data[i-1];
          end
        end
      end
    end
  end

  // Occupancy: +1 on push alone, -1 on pop alone, unchanged when both happen.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: table of per-cycle vectors for a DEPTH=4 chain, a scoreboard
// queue for output data order, plus hand-written sequences for async reset and a DEPTH=1 chain.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge or 1ns after rise.
module tb_pipe_reg_chain;

  typedef struct {
    bit         flush;
    bit         iv;
    logic [7:0] d;
    bit         ordy;
    bit         e_ir;
    bit         e_ov;
    int         e_cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_in, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] d_in, q_output;
  logic [2:0] count;

  logic       rst1, flush1, iv1, ir1, ov1, or1;
  logic [7:0] d1, q1;
  logic       cnt1;

  int tests  = 0;
  int failed = 0;

  logic [7:0] sb [$];
  vec_t       vecs [$];

  always #5 clk = ~clk;

  pipe_reg_chain #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_dut4 (
    .clk(clk), .rst_in(rst_in), .flush(flush), .d_in(d_in), .in_valid(in_valid),
    .in_ready(in_ready), .q_output(q_output), .out_valid(out_valid),
    .out_ready(out_ready), .count(count)
  );

  pipe_reg_chain #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h3C)) u_dut1 (
    .clk(clk), .rst_in(rst1), .flush(flush1), .d_in(d1), .in_valid(iv1),
    .in_ready(ir1), .q_output(q1), .out_valid(ov1),
    .out_ready(or1), .count(cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit f, input bit iv, input logic [7:0] d, input bit ordy,
                              input bit e_ir, input bit e_ov, input int e_cnt);
    vec_t r;
    r.flush = f; r.iv = iv; r.d = d; r.ordy = ordy;
    r.e_ir = e_ir; r.e_ov = e_ov; r.e_cnt = e_cnt;
    return r;
  endfunction

  // Drive one cycle, check before the edge, update the scoreboard, then clock.
  task automatic apply_row(input vec_t r, input int idx);
    string tag;
    flush     = r.flush;
    in_valid  = r.iv;
    d_in      = r.d;
    out_ready = r.ordy;
    @(negedge clk);
    tag = $sformatf("row%0d", idx);
    chk({tag, ".in_ready"},  32'(in_ready),  32'(r.e_ir));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(r.e_ov));
    chk({tag, ".count"},     32'(count),     32'(r.e_cnt));
    if (r.e_ov) begin
      if (sb.size() == 0) begin
        tests++; failed++;
        $display("FAIL %s.q_output: got %0d, scoreboard empty", tag, q_output);
      end else begin
        chk({tag, ".q_output"}, 32'(q_output), 32'(sb[0]));
      end
    end
    if (r.flush) begin
      sb.delete();
    end else begin
      if (r.e_ov && r.ordy) void'(sb.pop_front());
      if (r.iv && r.e_ir) sb.push_back(r.d);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Stream through with consumer ready: 87,2,68 appear after the 4th edge.
    vecs.push_back(mk(0,1,87,1,1,0,0)); vecs.push_back(mk(0,1,2,1,1,0,1));
    vecs.push_back(mk(0,1,68,1,1,0,2)); vecs.push_back(mk(0,0,0,1,1,0,3));
    vecs.push_back(mk(0,0,0,1,1,1,3));  vecs.push_back(mk(0,0,0,1,1,1,2));
    vecs.push_back(mk(0,0,0,1,1,1,1));  vecs.push_back(mk(0,0,0,0,1,0,0));
    // Fill to full under stall, then simultaneous pop+push, then drain.
    vecs.push_back(mk(0,1,10,0,1,0,0)); vecs.push_back(mk(0,1,20,0,1,0,1));
    vecs.push_back(mk(0,1,30,0,1,0,2)); vecs.push_back(mk(0,1,40,0,1,0,3));
    vecs.push_back(mk(0,1,50,0,0,1,4)); vecs.push_back(mk(0,1,50,0,0,1,4));
    vecs.push_back(mk(0,1,50,1,1,1,4)); vecs.push_back(mk(0,0,0,0,0,1,4));
    vecs.push_back(mk(0,0,0,1,1,1,4));  vecs.push_back(mk(0,0,0,1,1,1,3));
    vecs.push_back(mk(0,0,0,1,1,1,2));  vecs.push_back(mk(0,0,0,1,1,1,1));
    vecs.push_back(mk(0,0,0,0,1,0,0));
    // Bubble collapse under stall: 5, two idle cycles, 6; drain 5,6 back to back.
    vecs.push_back(mk(0,1,5,0,1,0,0));  vecs.push_back(mk(0,0,0,0,1,0,1));
    vecs.push_back(mk(0,0,0,0,1,0,1));  vecs.push_back(mk(0,1,6,0,1,0,1));
    vecs.push_back(mk(0,0,0,0,1,1,2));  vecs.push_back(mk(0,0,0,0,1,1,2));
    vecs.push_back(mk(0,0,0,0,1,1,2));  vecs.push_back(mk(0,0,0,1,1,1,2));
    vecs.push_back(mk(0,0,0,1,1,1,1));  vecs.push_back(mk(0,0,0,0,1,0,0));
    // Flush at count=3 with 99 offered; 99 must never appear, 11 follows cleanly.
    vecs.push_back(mk(0,1,1,0,1,0,0));  vecs.push_back(mk(0,1,2,0,1,0,1));
    vecs.push_back(mk(0,1,3,0,1,0,2));  vecs.push_back(mk(1,1,99,0,0,0,3));
    vecs.push_back(mk(0,0,0,1,1,0,0));  vecs.push_back(mk(0,1,11,1,1,0,0));
    vecs.push_back(mk(0,0,0,1,1,0,1));  vecs.push_back(mk(0,0,0,1,1,0,1));
    vecs.push_back(mk(0,0,0,1,1,0,1));  vecs.push_back(mk(0,0,0,1,1,1,1));
    vecs.push_back(mk(0,0,0,0,1,0,0));
    // Flush while full: out_valid stays up until the edge, then everything clears.
    vecs.push_back(mk(0,1,21,0,1,0,0)); vecs.push_back(mk(0,1,22,0,1,0,1));
    vecs.push_back(mk(0,1,23,0,1,0,2)); vecs.push_back(mk(0,1,24,0,1,0,3));
    vecs.push_back(mk(1,0,0,0,0,1,4));  vecs.push_back(mk(0,0,0,0,1,0,0));

    rst_in = 1'b0; flush = 1'b0; in_valid = 1'b0; d_in = '0; out_ready = 1'b0;
    rst1 = 1'b0; flush1 = 1'b0; iv1 = 1'b0; d1 = '0; or1 = 1'b0;
    #2;
    rst_in = 1'b1; rst1 = 1'b1;
    in_valid = 1'b1; d_in = 8'd87; out_ready = 1'b1;
    iv1 = 1'b1; d1 = 8'd87; or1 = 1'b1;

    // Held in reset across edges with valid input: nothing may be captured.
    @(negedge clk);
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.q_output",  32'(q_output),  32'd0);
    chk("rst.count",     32'(count),     32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst2.out_valid", 32'(out_valid), 32'd0);
    chk("rst2.count",     32'(count),     32'd0);
    chk("rst.d1.q_output",  32'(q1),  32'h3C);
    chk("rst.d1.out_valid", 32'(ov1), 32'd0);
    chk("rst.d1.in_ready",  32'(ir1), 32'd1);
    @(posedge clk); #1;
    rst_in = 1'b0; rst1 = 1'b0;
    iv1 = 1'b0; or1 = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_row(vecs[i], i);
    end

    // Async reset pulsed between edges with two words in flight.
    apply_row(mk(0,1,31,0,1,0,0), 100);
    apply_row(mk(0,1,32,0,1,0,1), 101);
    in_valid = 1'b0;
    #1;
    chk("arst.pre.count", 32'(count), 32'd2);
    #1;
    rst_in = 1'b1;
    #1;
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk("arst.count",     32'(count),     32'd0);
    chk("arst.q_output",  32'(q_output),  32'd0);
    chk("arst.in_ready",  32'(in_ready),  32'd1);
    sb.delete();
    #1;
    rst_in = 1'b0;
    apply_row(mk(0,0,0,1,1,0,0), 102);
    apply_row(mk(0,0,0,1,1,0,0), 103);
    apply_row(mk(0,0,0,1,1,0,0), 104);
    apply_row(mk(0,0,0,1,1,0,0), 105);

    // DEPTH=1: word visible right after the accepting edge; full+ready shifts.
    iv1 = 1'b1; d1 = 8'd7; or1 = 1'b0;
    @(negedge clk);
    chk("d1.pre.in_ready",  32'(ir1),  32'd1);
    chk("d1.pre.out_valid", 32'(ov1),  32'd0);
    chk("d1.pre.count",     32'(cnt1), 32'd0);
    @(posedge clk); #1;
    chk("d1.push.out_valid", 32'(ov1),  32'd1);
    chk("d1.push.q_output",  32'(q1),   32'd7);
    chk("d1.push.count",     32'(cnt1), 32'd1);
    chk("d1.full.in_ready",  32'(ir1),  32'd0);
    d1 = 8'd8; or1 = 1'b1;
    #1;
    chk("d1.poppush.in_ready", 32'(ir1), 32'd1);
    @(posedge clk); #1;
    chk("d1.poppush.q_output",  32'(q1),   32'd8);
    chk("d1.poppush.out_valid", 32'(ov1),  32'd1);
    chk("d1.poppush.count",     32'(cnt1), 32'd1);
    iv1 = 1'b0;
    @(posedge clk); #1;
    chk("d1.drain.out_valid", 32'(ov1),  32'd0);
    chk("d1.drain.count",     32'(cnt1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised elastic register chain: WIDTH-bit data through DEPTH register stages with valid/ready handshake, bubble collapsing, synchronous flush and occupancy count.
- Generalised successor of the single 8-bit d_in/q_output flop; used between CORDIC iteration stages so a stalled consumer does not lose data.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 4, number of register stages (>=1).
- RESET_VAL, 0, value loaded into every data register on reset (WIDTH bits).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all stage valids.
- d_in  input  WIDTH  input data.
- in_valid  input  1  d_in is valid.
- in_ready  output  1  chain accepts d_in this cycle.
- q_output  output  WIDTH  data of last stage.
- out_valid  output  1  q_output is valid.
- out_ready  input  1  consumer takes q_output this cycle.
- count  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- State: per stage i (0..DEPTH-1) data[i] (WIDTH) and v[i]. Stage 0 is input side; stage DEPTH-1 drives q_output=data[DEPTH-1], out_valid=v[DEPTH-1].
- Reset (rst_in=1, asynchronous, immediate): all v[i]=0, all data[i]=RESET_VAL, count=0. Therefore out_valid=0, q_output=RESET_VAL, in_ready=1 while rst_in=1 and flush=0. Reset mid-transfer drops all in-flight data; no partial state survives.
- Combinational handshake (no flush): take[DEPTH-1]=v[DEPTH-1]&out_ready; accept[i]=~v[i]|take[i]; take[i]=v[i]&accept[i+1] for i<DEPTH-1; in_ready=accept[0].
- Clock edge, flush=0:
  - stage 0, if accept[0]: v[0]<=in_valid; data[0]<=d_in only when in_valid=1.
  - stage i>0, if accept[i]: v[i]<=v[i-1]; data[i]<=data[i-1] only when v[i-1]=1.
  - stage with accept[i]=0 holds data and valid.
- Data registers never load when the incoming valid is 0; an empty stage keeps its old data, and q_output with out_valid=0 is don't-care for checking.
- Bubble collapse: an empty stage always accepts, so gaps close while the output is stalled; full throughput (one word per cycle) when out_ready=1 continuously.
- Latency: word accepted at edge t (in_valid&in_ready) is at q_output with out_valid=1 after edge t+DEPTH-1 if never stalled (DEPTH=1: visible right after acceptance edge).
- Ordering: strict FIFO; no word duplicated or dropped except by flush/reset.
- Full: all v[i]=1 and out_ready=0 -> in_ready=0, all stages hold. Full with out_ready=1 -> whole chain shifts, in_ready=1 (same-cycle pop+push).
- flush=1 at edge: all v[i]<=0, data unchanged, count<=0; input not captured; in_ready forced 0 while flush=1; out_valid unaffected until the edge. Flush overrides all handshakes.
- count: registered, equals number of v[i]=1 after every edge; updated +1 on push only, -1 on pop only, unchanged on simultaneous push+pop; range 0..DEPTH, never wraps.
- in_ready depends combinationally on out_ready (ready path through chain); accepted for DEPTH<=8.

Test Plan:
- WIDTH=8, DEPTH=4: assert rst_in with in_valid=1, d_in=87 -> in_ready=1, out_valid=0, q_output=0, count=0; nothing captured during reset.
- Release reset, out_ready=1, push 87,2,68 on consecutive edges -> out_valid rises after 4th edge from first push, q_output=87,2,68 on consecutive cycles, count peaks 3.
- out_ready=0, push 10,20,30,40,50 -> first four accepted, count=4, in_ready=0 on fifth, q_output=10 held; raise out_ready one cycle with in_valid=1 d_in=50 -> 10 popped, 50 pushed same edge, count stays 4.
- Bubble collapse: push 5, idle 2 cycles, push 6 with out_ready=0 -> stages compact, count=2, later drain order 5,6 with no gap.
- flush=1 with count=3 and in_valid=1 d_in=99 -> in_ready=0, next cycle count=0, out_valid=0; 99 never appears at output.
- Async reset mid-stream (rst_in pulsed between edges, count=2) -> out_valid and count drop to 0 immediately, q_output=RESET_VAL; DEPTH=1 variant: push 7 -> q_output=7 out_valid=1 after acceptance edge.
